// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: 32-bit XGMII-style rx ingress. It strips the preamble, checks the CRC-32 and length, and emits words with keep and status flags.
// Defining ETH_RX_STATS_EN adds the stat_ok/stat_err frame counters.
module eth_rx_fcs_check #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_ctrl,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_fcs_err,
  output logic        m_len_err,
  output logic        m_ctl_err
`ifdef ETH_RX_STATS_EN
  ,
  output logic [31:0] stat_ok,
  output logic [31:0] stat_err
`endif
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_PAYLOAD  = 2'd2;
  localparam logic [1:0] S_ABORT    = 2'd3;

  localparam logic [7:0]  CH_TERM     = 8'hFD;
  localparam logic [7:0]  CH_IDLE     = 8'h07;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] START_WORD  = 32'h5555_55FB;
  localparam logic [31:0] SFD_WORD    = 32'hD555_5555;

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME);

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] v;
    v = c ^ {24'd0, b};
    for (int n = 0; n < 8; n++) begin
      v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
    end
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] c, input logic [2:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic lenBad(input logic [CNT_W-1:0] c);
    return (c < MIN_CNT) || (c > MAX_CNT);
  endfunction

  logic [1:0]       r_state;
  logic [31:0]      r_crc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hold_vld;
  logic [31:0]      r_hold_data;
  logic             r_tail_vld;
  logic [31:0]      r_tail_data;
  logic [3:0]       r_tail_keep;
  logic             r_tail_fcs;
  logic             r_tail_len;
  logic [31:0]      r_m_data;
  logic [3:0]       r_m_keep;
  logic             r_m_valid;
  logic             r_m_last;
  logic             r_m_fcs;
  logic             r_m_len;
  logic             r_m_ctl;

  logic [3:0]       w_is_term;
  logic [3:0]       w_is_idle;
  logic [1:0]       w_first_lane;
  logic             w_any_ctrl;
  logic             w_term_ok;
  logic             w_exit_abort;
  logic             w_start_word;
  logic             w_sfd_word;
  logic [31:0]      w_crc_b [0:4];
  logic [31:0]      w_crc_fin;
  logic [CNT_W-1:0] w_cnt_word;
  logic [CNT_W-1:0] w_cnt_fin;
  logic [3:0]       w_part_keep;

  // Lane decode: the lowest control lane decides whether the word terminates or aborts.
  always_comb begin
    w_first_lane = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_is_term[i] = rx_ctrl[i] && (rx_data[8*i +: 8] == CH_TERM);
      w_is_idle[i] = rx_ctrl[i] && (rx_data[8*i +: 8] == CH_IDLE);
    end
    for (int i = 3; i >= 0; i--) begin
      if (rx_ctrl[i]) w_first_lane = 2'(i);
    end
    w_any_ctrl   = |rx_ctrl;
    w_term_ok    = w_any_ctrl && w_is_term[w_first_lane];
    w_exit_abort = |(w_is_term | w_is_idle);
    w_start_word = (rx_ctrl == 4'b0001) && (rx_data == START_WORD);
    w_sfd_word   = (rx_ctrl == 4'b0000) && (rx_data == SFD_WORD);
  end

  always_comb begin
    w_crc_b[0] = r_crc;
    for (int i = 0; i < 4; i++) begin
      w_crc_b[i+1] = crcByte(w_crc_b[i], rx_data[8*i +: 8]);
    end
    w_crc_fin  = w_crc_b[w_first_lane];
    w_cnt_word = satAdd(r_cnt, 3'd4);
    w_cnt_fin  = satAdd(r_cnt, {1'b0, w_first_lane});
    case (w_first_lane)
      2'd1:    w_part_keep = 4'h1;
      2'd2:    w_part_keep = 4'h3;
      2'd3:    w_part_keep = 4'h7;
      default: w_part_keep = 4'h0;
    endcase
  end

  logic [1:0]       w_state_nxt;
  logic [31:0]      w_crc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_hold_vld_nxt;
  logic [31:0]      w_hold_data_nxt;
  logic             w_tail_vld_nxt;
  logic [31:0]      w_tail_data_nxt;
  logic [3:0]       w_tail_keep_nxt;
  logic             w_tail_fcs_nxt;
  logic             w_tail_len_nxt;
  logic [31:0]      w_o_data;
  logic [3:0]       w_o_keep;
  logic             w_o_valid;
  logic             w_o_last;
  logic             w_o_fcs;
  logic             w_o_len;
  logic             w_o_ctl;

  // Each data word sits in the hold register until the next word shows whether it is the last one.
  always_comb begin
    w_state_nxt     = r_state;
    w_crc_nxt       = r_crc;
    w_cnt_nxt       = r_cnt;
    w_hold_vld_nxt  = r_hold_vld;
    w_hold_data_nxt = r_hold_data;
    w_tail_vld_nxt  = 1'b0;
    w_tail_data_nxt = '0;
    w_tail_keep_nxt = '0;
    w_tail_fcs_nxt  = 1'b0;
    w_tail_len_nxt  = 1'b0;
    w_o_data        = '0;
    w_o_keep        = '0;
    w_o_valid       = 1'b0;
    w_o_last        = 1'b0;
    w_o_fcs         = 1'b0;
    w_o_len         = 1'b0;
    w_o_ctl         = 1'b0;

    if (r_tail_vld) begin
      w_o_valid = 1'b1;
      w_o_last  = 1'b1;
      w_o_data  = r_tail_data;
      w_o_keep  = r_tail_keep;
      w_o_fcs   = r_tail_fcs;
      w_o_len   = r_tail_len;
    end

    case (r_state)
      S_IDLE: begin
        w_crc_nxt      = CRC_INIT;
        w_cnt_nxt      = '0;
        w_hold_vld_nxt = 1'b0;
        if (w_start_word) w_state_nxt = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        w_state_nxt = w_sfd_word ? S_PAYLOAD : S_IDLE;
      end
      S_PAYLOAD: begin
        if (!w_any_ctrl) begin
          w_crc_nxt = w_crc_b[4];
          w_cnt_nxt = w_cnt_word;
          if (w_cnt_word <= MAX_CNT) begin
            if (r_hold_vld) begin
              w_o_valid = 1'b1;
              w_o_data  = r_hold_data;
              w_o_keep  = 4'hF;
            end
            w_hold_vld_nxt  = 1'b1;
            w_hold_data_nxt = rx_data;
          end
        end else if (w_term_ok) begin
          w_state_nxt    = S_IDLE;
          w_crc_nxt      = w_crc_fin;
          w_cnt_nxt      = w_cnt_fin;
          w_hold_vld_nxt = 1'b0;
          if ((w_first_lane == 2'd0) || (w_cnt_fin > MAX_CNT)) begin
            if (r_hold_vld) begin
              w_o_valid = 1'b1;
              w_o_last  = 1'b1;
              w_o_data  = r_hold_data;
              w_o_keep  = 4'hF;
              w_o_fcs   = (w_crc_fin != CRC_RESIDUE);
              w_o_len   = lenBad(w_cnt_fin);
            end
          end else begin
            if (r_hold_vld) begin
              w_o_valid = 1'b1;
              w_o_data  = r_hold_data;
              w_o_keep  = 4'hF;
            end
            w_tail_vld_nxt  = 1'b1;
            w_tail_keep_nxt = w_part_keep;
            w_tail_fcs_nxt  = (w_crc_fin != CRC_RESIDUE);
            w_tail_len_nxt  = lenBad(w_cnt_fin);
            for (int i = 0; i < 3; i++) begin
              if (w_part_keep[i]) w_tail_data_nxt[8*i +: 8] = rx_data[8*i +: 8];
            end
          end
        end else begin
          w_state_nxt    = S_ABORT;
          w_hold_vld_nxt = 1'b0;
          if (r_hold_vld) begin
            w_o_valid = 1'b1;
            w_o_last  = 1'b1;
            w_o_data  = r_hold_data;
            w_o_keep  = 4'hF;
            w_o_fcs   = (r_crc != CRC_RESIDUE);
            w_o_len   = lenBad(r_cnt);
            w_o_ctl   = 1'b1;
          end
        end
      end
      default: begin
        w_hold_vld_nxt = 1'b0;
        if (w_exit_abort) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_crc       <= CRC_INIT;
      r_cnt       <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_tail_vld  <= 1'b0;
      r_tail_data <= '0;
      r_tail_keep <= '0;
      r_tail_fcs  <= 1'b0;
      r_tail_len  <= 1'b0;
      r_m_data    <= '0;
      r_m_keep    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_fcs     <= 1'b0;
      r_m_len     <= 1'b0;
      r_m_ctl     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_crc       <= w_crc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_tail_vld  <= w_tail_vld_nxt;
      r_tail_data <= w_tail_data_nxt;
      r_tail_keep <= w_tail_keep_nxt;
      r_tail_fcs  <= w_tail_fcs_nxt;
      r_tail_len  <= w_tail_len_nxt;
      r_m_data    <= w_o_data;
      r_m_keep    <= w_o_keep;
      r_m_valid   <= w_o_valid;
      r_m_last    <= w_o_last;
      r_m_fcs     <= w_o_fcs;
      r_m_len     <= w_o_len;
      r_m_ctl     <= w_o_ctl;
    end
  end

  assign m_data    = r_m_data;
  assign m_keep    = r_m_keep;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign m_fcs_err = r_m_fcs;
  assign m_len_err = r_m_len;
  assign m_ctl_err = r_m_ctl;

`ifdef ETH_RX_STATS_EN
  logic [31:0] r_stat_ok;
  logic [31:0] r_stat_err;

  // Counters step on the same edge that registers m_last, so they update as the frame closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_ok  <= '0;
      r_stat_err <= '0;
    end else if (w_o_last) begin
      if (w_o_fcs || w_o_len || w_o_ctl) r_stat_err <= r_stat_err + 32'd1;
      else                               r_stat_ok  <= r_stat_ok + 32'd1;
    end
  end

  assign stat_ok  = r_stat_ok;
  assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check: directed frames (good, partial tail, bad FCS, runt, giant, abort, reset) against eth_rx_fcs_check.
// Expected words, keeps and flags are derived from the frame bytes the bench itself builds.
module tb_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_data;
  logic [3:0]  rx_ctrl;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_last;
  logic        m_fcs_err;
  logic        m_len_err;
  logic        m_ctl_err;
`ifdef ETH_RX_STATS_EN
  logic [31:0] stat_ok;
  logic [31:0] stat_err;
`endif

  eth_rx_fcs_check dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_ctrl   (rx_ctrl),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_fcs_err (m_fcs_err),
    .m_len_err (m_len_err),
    .m_ctl_err (m_ctl_err)
`ifdef ETH_RX_STATS_EN
    ,
    .stat_ok   (stat_ok),
    .stat_err  (stat_err)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]  frame [0:1999];
  int          frameLen;
  int          checks = 0;
  int          failures = 0;

  logic [31:0] capData [0:511];
  logic [3:0]  capKeep [0:511];
  logic        capLast [0:511];
  logic        capFcs  [0:511];
  logic        capLen  [0:511];
  logic        capCtl  [0:511];
  int          capCount = 0;
  int          lastCount = 0;
  int          badFlags = 0;

  // Output monitor: record every emitted word and any status flag raised off a last word.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (m_valid === 1'b1) begin
        if (capCount < 512) begin
          capData[capCount] = m_data;
          capKeep[capCount] = m_keep;
          capLast[capCount] = m_last;
          capFcs[capCount]  = m_fcs_err;
          capLen[capCount]  = m_len_err;
          capCtl[capCount]  = m_ctl_err;
        end
        capCount++;
        if (m_last === 1'b1) lastCount++;
      end
      if ((m_last !== 1'b1) && ((m_fcs_err | m_len_err | m_ctl_err) !== 1'b0)) badFlags++;
      if ((m_last === 1'b1) && (m_valid !== 1'b1)) badFlags++;
    end
  end

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] v;
    v = c ^ {24'd0, b};
    for (int n = 0; n < 8; n++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic buildFrame(input int len);
    logic [31:0] crc;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      frame[i] = 8'((i * 13 + 5) & 255);
      crc = crcByte(crc, frame[i]);
    end
    crc = ~crc;
    frame[len-4] = crc[7:0];
    frame[len-3] = crc[15:8];
    frame[len-2] = crc[23:16];
    frame[len-1] = crc[31:24];
    frameLen = len;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] c);
    @(negedge clk);
    rx_data = d;
    rx_ctrl = c;
  endtask

  task automatic sendIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h07070707, 4'hF);
  endtask

  task automatic clearCapture();
    capCount  = 0;
    lastCount = 0;
  endtask

  // Sends start, SFD, frame words and terminator; optional error char or reset at a given word.
  task automatic sendFrame(input int abortWord, input int abortLane, input int resetWord);
    logic [31:0] d;
    logic [3:0]  c;
    int nFull;
    int k;
    nFull = frameLen / 4;
    k     = frameLen % 4;
    applyStimulus(32'h555555FB, 4'b0001);
    applyStimulus(32'hD5555555, 4'b0000);
    for (int w = 0; w < nFull; w++) begin
      if (w == resetWord) begin
        @(negedge clk);
        rst = 1'b1;
        rx_data = 32'h07070707;
        rx_ctrl = 4'hF;
        #1;
        checkOutput("rstAsyncValid", {31'd0, m_valid}, 32'd0);
        checkOutput("rstAsyncData", m_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sendIdle(4);
        return;
      end
      for (int i = 0; i < 4; i++) d[8*i +: 8] = frame[4*w + i];
      c = 4'b0000;
      if (w == abortWord) begin
        d[8*abortLane +: 8] = 8'hFE;
        c[abortLane] = 1'b1;
      end
      applyStimulus(d, c);
    end
    d = 32'h07070707;
    c = 4'hF;
    for (int i = 0; i < k; i++) begin
      d[8*i +: 8] = frame[4*nFull + i];
      c[i] = 1'b0;
    end
    d[8*k +: 8] = 8'hFD;
    applyStimulus(d, c);
    sendIdle(4);
  endtask

  task automatic checkFrame(input string tag, input int expWords, input logic [3:0] expLastKeep,
                            input logic expFcs, input logic expLen, input logic expCtl);
    int idx;
    int dataBad;
    logic [31:0] exp;
    logic [31:0] mask;
    idx = (capCount > 0) ? capCount - 1 : 0;
    checkOutput({tag, ".words"}, capCount, expWords);
    checkOutput({tag, ".lastCount"}, lastCount, 1);
    checkOutput({tag, ".last"}, {31'd0, capLast[idx]}, 32'd1);
    checkOutput({tag, ".keep"}, {28'd0, capKeep[idx]}, {28'd0, expLastKeep});
    checkOutput({tag, ".fcs"}, {31'd0, capFcs[idx]}, {31'd0, expFcs});
    checkOutput({tag, ".len"}, {31'd0, capLen[idx]}, {31'd0, expLen});
    checkOutput({tag, ".ctl"}, {31'd0, capCtl[idx]}, {31'd0, expCtl});
    dataBad = 0;
    for (int j = 0; j < expWords && j < capCount && j < 512; j++) begin
      exp  = '0;
      mask = '0;
      for (int i = 0; i < 4; i++) begin
        if (4*j + i < frameLen) begin
          exp[8*i +: 8]  = frame[4*j + i];
          mask[8*i +: 8] = 8'hFF;
        end
      end
      if ((capData[j] & mask) !== exp) dataBad++;
    end
    checkOutput({tag, ".dataWords"}, dataBad, 0);
  endtask

  initial begin
    int emittedBytes;
    int idx;
    int dataBad;
    logic [31:0] exp;

    rst = 1'b1;
    rx_data = 32'h07070707;
    rx_ctrl = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("reset.valid", {31'd0, m_valid}, 32'd0);
    checkOutput("reset.last", {31'd0, m_last}, 32'd0);
    checkOutput("reset.keep", {28'd0, m_keep}, 32'd0);
    checkOutput("reset.data", m_data, 32'd0);
    checkOutput("reset.errs", {29'd0, m_fcs_err, m_len_err, m_ctl_err}, 32'd0);
    rst = 1'b0;
    sendIdle(3);

    $display("[TB] good 64/65/66/67-byte frames");
    buildFrame(64); clearCapture(); sendFrame(-1, 0, -1);
    checkFrame("good64", 16, 4'hF, 1'b0, 1'b0, 1'b0);
    buildFrame(65); clearCapture(); sendFrame(-1, 0, -1);
    checkFrame("good65", 17, 4'h1, 1'b0, 1'b0, 1'b0);
    buildFrame(66); clearCapture(); sendFrame(-1, 0, -1);
    checkFrame("good66", 17, 4'h3, 1'b0, 1'b0, 1'b0);
    buildFrame(67); clearCapture(); sendFrame(-1, 0, -1);
    checkFrame("good67", 17, 4'h7, 1'b0, 1'b0, 1'b0);

    $display("[TB] corrupted payload bit");
    buildFrame(64); frame[20] = frame[20] ^ 8'h04; clearCapture(); sendFrame(-1, 0, -1);
    checkFrame("fcsBad", 16, 4'hF, 1'b1, 1'b0, 1'b0);

    $display("[TB] runt 60-byte frame");
    buildFrame(60); clearCapture(); sendFrame(-1, 0, -1);
    checkFrame("runt60", 15, 4'hF, 1'b0, 1'b1, 1'b0);

    $display("[TB] giant 1600-byte frame");
    buildFrame(1600); clearCapture(); sendFrame(-1, 0, -1);
    idx = (capCount > 0) ? capCount - 1 : 0;
    emittedBytes = 0;
    for (int j = 0; j < capCount && j < 512; j++)
      for (int i = 0; i < 4; i++) emittedBytes += int'(capKeep[j][i]);
    checkOutput("giant.lastCount", lastCount, 1);
    checkOutput("giant.last", {31'd0, capLast[idx]}, 32'd1);
    checkOutput("giant.len", {31'd0, capLen[idx]}, 32'd1);
    checkOutput("giant.ctl", {31'd0, capCtl[idx]}, 32'd0);
    checkOutput("giant.bytesLe1519", {31'd0, emittedBytes <= 1519}, 32'd1);
    checkOutput("giant.bytesGe1500", {31'd0, emittedBytes >= 1500}, 32'd1);

    $display("[TB] error char lane 2 of word 8");
    buildFrame(64); clearCapture(); sendFrame(8, 2, -1);
    checkOutput("abort.words", capCount, 8);
    checkOutput("abort.lastCount", lastCount, 1);
    checkOutput("abort.last", {31'd0, capLast[7]}, 32'd1);
    checkOutput("abort.ctl", {31'd0, capCtl[7]}, 32'd1);
    dataBad = 0;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 4; i++) exp[8*i +: 8] = frame[4*j + i];
      if (capData[j] !== exp) dataBad++;
    end
    checkOutput("abort.dataWords", dataBad, 0);

    $display("[TB] reset mid-frame then good frame");
    buildFrame(64); clearCapture(); sendFrame(-1, 0, 5);
    checkOutput("rstFrame.lastCount", lastCount, 0);
    clearCapture(); sendFrame(-1, 0, -1);
    checkFrame("afterRst", 16, 4'hF, 1'b0, 1'b0, 1'b0);

    $display("[TB] zero-byte frame");
    frameLen = 0; clearCapture(); sendFrame(-1, 0, -1);
    checkOutput("empty.words", capCount, 0);
    checkOutput("empty.lastCount", lastCount, 0);

    checkOutput("flagsOffLast", badFlags, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
